// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bundle: decoded instruction fields in, stall/issue verdict and busy map out.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned MAX_MC_LAT = 30
);
  localparam int unsigned NREGS = 1 << REG_W;
  localparam int unsigned CNT_W = $clog2(MAX_MC_LAT + PIPE_LAT + 1);

  logic             has_forwarding;
  logic             issue_valid;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             src2_used;
  logic             is_branch;
  logic             wb_en;
  logic [REG_W-1:0] dest;
  logic [1:0]       lat_class;
  logic [CNT_W-1:0] mc_lat;
  logic             flush;
  logic             stall;
  logic             issue_fire;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output has_forwarding, issue_valid, src1, src2, src2_used, is_branch,
           wb_en, dest, lat_class, mc_lat, flush,
    input  stall, issue_fire, busy_vec
  );

  modport slave (
    input  has_forwarding, issue_valid, src1, src2, src2_used, is_branch,
           wb_en, dest, lat_class, mc_lat, flush,
    output stall, issue_fire, busy_vec
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for the ID stage: detects RAW, WAW and
// multi-cycle-unit structural hazards and holds the ID instruction until they clear.
module hazard_scoreboard #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned MAX_MC_LAT = 30
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned NREGS = 1 << REG_W;
  localparam int unsigned CNT_W = $clog2(MAX_MC_LAT + PIPE_LAT + 1);

  localparam logic [CNT_W-1:0] PIPE_CNT    = CNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0] PIPE_CNT_LD = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] MAX_MC_CNT  = CNT_W'(MAX_MC_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [1:0] LC_LOAD = 2'd1;
  localparam logic [1:0] LC_MC   = 2'd2;

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] is_ld;
  logic [CNT_W-1:0] mc_cnt;

  logic             is_mc;
  logic [CNT_W-1:0] mc_sat;
  logic [CNT_W-1:0] new_lat;
  logic [CNT_W-1:0] allow1;
  logic [CNT_W-1:0] allow2;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             mc_busy;
  logic             stall_c;
  logic             fire_c;
  logic             load_en;
  logic [NREGS-1:0] busy_c;

  // Residual count a consumer can tolerate: zero when operands come from the register file in ID.
  function automatic logic [CNT_W-1:0] allowed(input logic fwd, input logic br, input logic ld);
    if (!fwd || br) return '0;
    return ld ? PIPE_CNT_LD : PIPE_CNT;
  endfunction

  // Latency of the ID instruction's own write.
  always_comb begin
    is_mc   = (bus.lat_class == LC_MC);
    mc_sat  = (bus.mc_lat > MAX_MC_CNT) ? MAX_MC_CNT : bus.mc_lat;
    new_lat = is_mc ? (PIPE_CNT + mc_sat) : PIPE_CNT;
  end

  // Hazard decision; reset forces the instruction to neither stall nor issue.
  always_comb begin
    allow1  = allowed(bus.has_forwarding, bus.is_branch, is_ld[bus.src1]);
    allow2  = allowed(bus.has_forwarding, bus.is_branch, is_ld[bus.src2]);
    raw1    = (bus.src1 != '0) && (cnt[bus.src1] > allow1);
    raw2    = bus.src2_used && (bus.src2 != '0) && (cnt[bus.src2] > allow2);
    waw     = bus.wb_en && (bus.dest != '0) && (cnt[bus.dest] > new_lat);
    mc_busy = is_mc && (mc_cnt != '0);
    stall_c = rst && bus.issue_valid && !bus.flush && (raw1 || raw2 || waw || mc_busy);
    fire_c  = rst && bus.issue_valid && !bus.flush && !stall_c;
    load_en = fire_c && bus.wb_en && (bus.dest != '0);
  end

  always_comb begin
    busy_c = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      busy_c[r] = (cnt[r] != '0);
    end
  end

  assign bus.stall      = stall_c;
  assign bus.issue_fire = fire_c;
  assign bus.busy_vec   = busy_c;

  // Per-register countdown; a new issue to the same register overrides the decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt[r]   <= '0;
        is_ld[r] <= 1'b0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (load_en && (bus.dest == REG_W'(r))) begin
          cnt[r]   <= new_lat;
          is_ld[r] <= (bus.lat_class == LC_LOAD);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Single multi-cycle unit occupancy, reserved regardless of whether the op writes back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc_cnt <= '0;
    end else if (fire_c && is_mc) begin
      mc_cnt <= mc_sat;
    end else if (mc_cnt != '0) begin
      mc_cnt <= mc_cnt - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: timestamp-based readiness model checked every
// cycle, plus directed sequences with hand-computed stall/issue/busy expectations.
module tb_hazard_scoreboard;
  localparam int NREGS = 32;
  localparam int PIPE  = 2;
  localparam int MAXMC = 30;

  logic clk = 1'b0;
  logic rst;

  hazard_scoreboard_if bus ();
  hazard_scoreboard dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model: absolute cycle at which each register's value and the multi-cycle unit free up.
  int ready_at [NREGS];
  bit ld_flag  [NREGS];
  int mc_free = 0;
  int cyc = 0;

  int checks = 0;
  int failures = 0;

  string       pin_name = "";
  int          pin_stall = -1;
  int          pin_fire = -1;
  logic [31:0] pin_mask = '0;
  logic [31:0] pin_val = '0;

  function automatic int remain(input int r);
    if (r == 0) return 0;
    return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  function automatic int mc_sat();
    int m;
    m = int'(bus.mc_lat);
    return (m > MAXMC) ? MAXMC : m;
  endfunction

  function automatic int new_lat();
    return (bus.lat_class == 2'd2) ? PIPE + mc_sat() : PIPE;
  endfunction

  function automatic int allow(input int r);
    if (!bus.has_forwarding || bus.is_branch) return 0;
    return ld_flag[r] ? PIPE - 1 : PIPE;
  endfunction

  function automatic bit exp_stall();
    bit h;
    if (rst !== 1'b1 || !bus.issue_valid || bus.flush) return 1'b0;
    h = remain(int'(bus.src1)) > allow(int'(bus.src1));
    if (bus.src2_used && remain(int'(bus.src2)) > allow(int'(bus.src2))) h = 1'b1;
    if (bus.wb_en && bus.dest != '0 && remain(int'(bus.dest)) > new_lat()) h = 1'b1;
    if (bus.lat_class == 2'd2 && mc_free > cyc) h = 1'b1;
    return h;
  endfunction

  function automatic bit exp_fire();
    return (rst === 1'b1) && bus.issue_valid && !bus.flush && !exp_stall();
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < NREGS; r++) b[r] = (remain(r) != 0);
    return b;
  endfunction

  function automatic logic [31:0] bitm(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  // Model state update, mirroring the asynchronous clear.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        ready_at[r] <= 0;
        ld_flag[r]  <= 1'b0;
      end
      mc_free <= 0;
    end else begin
      if (exp_fire()) begin
        if (bus.wb_en && bus.dest != '0) begin
          ready_at[bus.dest] <= cyc + 1 + new_lat();
          ld_flag[bus.dest]  <= (bus.lat_class == 2'd1);
        end
        if (bus.lat_class == 2'd2) mc_free <= cyc + 1 + mc_sat();
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  // Compare process: model every cycle, directed pins when present.
  always @(negedge clk) begin
    chk("model/stall", 32'(bus.stall), 32'(exp_stall()));
    chk("model/issue_fire", 32'(bus.issue_fire), 32'(exp_fire()));
    chk("model/busy_vec", bus.busy_vec, exp_busy());
    if (pin_stall >= 0) chk({pin_name, "/stall"}, 32'(bus.stall), 32'(pin_stall));
    if (pin_fire >= 0)  chk({pin_name, "/issue_fire"}, 32'(bus.issue_fire), 32'(pin_fire));
    if (pin_mask != '0) chk({pin_name, "/busy_vec"}, bus.busy_vec & pin_mask, pin_val);
  end

  task automatic ins(input bit v, input int s1, input int s2, input bit s2u, input bit br,
                     input bit we, input int d, input int lc, input int ml);
    bus.issue_valid = v;
    bus.src1        = 5'(s1);
    bus.src2        = 5'(s2);
    bus.src2_used   = s2u;
    bus.is_branch   = br;
    bus.wb_en       = we;
    bus.dest        = 5'(d);
    bus.lat_class   = 2'(lc);
    bus.mc_lat      = 6'(ml);
    bus.flush       = 1'b0;
  endtask

  task automatic tick(input string nm, input int ps, input int pf,
                      input logic [31:0] m, input logic [31:0] v);
    pin_name  = nm;
    pin_stall = ps;
    pin_fire  = pf;
    pin_mask  = m;
    pin_val   = v;
    @(posedge clk);
    #1;
    pin_stall = -1;
    pin_fire  = -1;
    pin_mask  = '0;
  endtask

  task automatic idle(input int n);
    ins(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick("idle", 0, 0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.has_forwarding = 1'b0;
    ins(1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 4, 0, 0);
    @(posedge clk);
    #1;
    tick("reset0", 0, 0, 32'hFFFF_FFFF, '0);
    tick("reset1", 0, 0, 32'hFFFF_FFFF, '0);
    rst = 1'b1;

    // No forwarding: ALU producer r3, dependent ALU consumer.
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 3, 0, 0);
    tick("alu_r3", 0, 1, bitm(3), '0);
    ins(1'b1, 3, 1, 1'b1, 1'b0, 1'b1, 4, 0, 0);
    tick("nofwd_s1", 1, 0, bitm(3), bitm(3));
    tick("nofwd_s2", 1, 0, '0, '0);
    tick("nofwd_go", 0, 1, bitm(3), '0);
    idle(3);

    // Forwarding: load-use, load-to-branch, ALU-to-ALU.
    bus.has_forwarding = 1'b1;
    ins(1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 5, 1, 0);
    tick("lw_r5", 0, 1, bitm(5), '0);
    ins(1'b1, 5, 0, 1'b1, 1'b0, 1'b1, 6, 0, 0);
    tick("ldu_s", 1, 0, bitm(5), bitm(5));
    tick("ldu_go", 0, 1, '0, '0);
    idle(3);
    ins(1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 5, 1, 0);
    tick("lw_r5b", 0, 1, '0, '0);
    ins(1'b1, 5, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    tick("br_s1", 1, 0, '0, '0);
    tick("br_s2", 1, 0, '0, '0);
    tick("br_go", 0, 1, '0, '0);
    idle(3);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 6, 0, 0);
    tick("add_r6", 0, 1, '0, '0);
    ins(1'b1, 1, 6, 1'b0, 1'b0, 1'b1, 7, 0, 0);
    tick("addi_go", 0, 1, '0, '0);
    ins(1'b1, 7, 0, 1'b0, 1'b0, 1'b1, 9, 0, 0);
    tick("fwd_alu_go", 0, 1, bitm(7), bitm(7));
    idle(3);

    // Multi-cycle RAW, structural, and latency saturation without forwarding.
    bus.has_forwarding = 1'b0;
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 7, 2, 4);
    tick("mul_r7", 0, 1, '0, '0);
    ins(1'b1, 7, 0, 1'b0, 1'b0, 1'b1, 10, 0, 0);
    for (int i = 0; i < 6; i++) tick("mul_raw", 1, 0, bitm(7), bitm(7));
    tick("mul_raw_go", 0, 1, bitm(7), '0);
    idle(3);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 7, 2, 4);
    tick("mul_r7b", 0, 1, '0, '0);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 11, 2, 4);
    for (int i = 0; i < 4; i++) tick("struct", 1, 0, '0, '0);
    tick("struct_go", 0, 1, '0, '0);
    idle(8);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 12, 2, 31);
    tick("mul_sat", 0, 1, '0, '0);
    ins(1'b1, 12, 0, 1'b0, 1'b0, 1'b1, 13, 0, 0);
    for (int i = 0; i < 32; i++) tick("sat_raw", 1, 0, '0, '0);
    tick("sat_go", 0, 1, bitm(12), '0);
    idle(3);

    // WAW behind a slow multi-cycle write, then the reload to PIPE_LAT.
    bus.has_forwarding = 1'b1;
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 8, 2, 4);
    tick("mul_r8", 0, 1, '0, '0);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 8, 0, 0);
    for (int i = 0; i < 4; i++) tick("waw", 1, 0, '0, '0);
    tick("waw_go", 0, 1, '0, '0);
    ins(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick("waw_reload1", 0, 0, bitm(8), bitm(8));
    tick("waw_reload2", 0, 0, bitm(8), bitm(8));
    tick("waw_done", 0, 0, bitm(8), '0);

    // Register 0 is never tracked.
    bus.has_forwarding = 1'b0;
    ins(1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    tick("r0_write", 0, 1, bitm(0), '0);
    tick("r0_again", 0, 1, bitm(0), '0);

    // Flush beats a hazard and blocks scoreboard / unit loads.
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 3, 0, 0);
    tick("add_r3f", 0, 1, '0, '0);
    ins(1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 4, 0, 0);
    bus.flush = 1'b1;
    tick("flush_haz", 0, 0, '0, '0);
    ins(1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 13, 1, 0);
    bus.flush = 1'b1;
    tick("flush_lw", 0, 0, bitm(13), '0);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 14, 2, 4);
    bus.flush = 1'b1;
    tick("flush_mul", 0, 0, bitm(13), '0);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 15, 2, 4);
    tick("mul_after_flush", 0, 1, bitm(14), '0);
    idle(8);

    // Asynchronous reset while r3 and the multi-cycle unit are busy.
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 9, 2, 4);
    tick("mul_r9", 0, 1, '0, '0);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 3, 0, 0);
    tick("add_r3r", 0, 1, '0, '0);
    ins(1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 4, 0, 0);
    #2;
    rst = 1'b0;
    tick("rst_async", 0, 0, 32'hFFFF_FFFF, '0);
    tick("rst_hold", 0, 0, 32'hFFFF_FFFF, '0);
    rst = 1'b1;
    tick("rst_rel_go", 0, 1, bitm(3), '0);
    ins(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 14, 2, 2);
    tick("rst_mc_go", 0, 1, '0, '0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
